// File: rtl/jm_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jm_engine_pkg
// Brief    : Shared types and constants for the per-kernel dispatch endpoint.
// Revision : 1.0 - initial release
// ============================================================================
package jm_engine_pkg;

  // Dispatch endpoint states (2-bit encoding)
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_RUN      = 2'd2,
    ST_REPORT   = 2'd3
  } state_e;

  // Return code reported when the kernel is aborted by the watchdog
  localparam logic [31:0] RC_TIMEOUT = 32'hDEAD_0001;

endpackage : jm_engine_pkg
`default_nettype wire

// File: rtl/jm_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : jm_watchdog
// Brief    : Cycle counter with clear/enable that pulses expire_o for one
//            cycle when the enabled count reaches LIMIT-1. A LIMIT of 0
//            removes the counter entirely and holds expire_o low.
// Revision : 1.0 - initial release
// ============================================================================
module jm_watchdog #(
  parameter int unsigned LIMIT = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  if (LIMIT == 0) begin : g_off
    // Watchdog disabled: inputs are intentionally left without effect
    logic unused_off;
    assign unused_off = ^{clk_i, rst_ni, clr_i, en_i};
    assign expire_o   = 1'b0;
  end else begin : g_on
    localparam int unsigned CW   = $clog2(LIMIT) + 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over enable; otherwise hold
    always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
        cnt_d = '0;
      end else if (en_i) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // Expiry is only meaningful while counting and not being cleared
    assign expire_o = en_i && !clr_i && (cnt_q == LAST);
  end

endmodule : jm_watchdog
`default_nettype wire

// File: rtl/jm_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : jm_engine_if
// Brief    : Kernel-side endpoint of the scheduler dispatch link. Accepts a
//            job descriptor, hands it to the kernel over valid/ready, waits
//            for completion or watchdog timeout and reports back.
// Revision : 1.0 - initial release
// ============================================================================
module jm_engine_if
  import jm_engine_pkg::*;
#(
  parameter int unsigned HOST_DWIDTH    = 1024,
  parameter int unsigned RC_WIDTH       = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   engine_start_i,
  input  logic [HOST_DWIDTH-1:0] jd_payload_i,
  output logic                   engine_done_o,
  output logic [RC_WIDTH-1:0]    return_code_o,
  output logic                   job_valid_o,
  input  logic                   job_ready_i,
  output logic [HOST_DWIDTH-1:0] job_data_o,
  input  logic                   kern_done_i,
  input  logic [RC_WIDTH-1:0]    kern_rc_i,
  output logic                   kern_abort_o,
  output logic                   busy_o,
  output logic [CNT_WIDTH-1:0]   job_count_o,
  output logic [1:0]             err_sticky_o
);

  localparam logic [RC_WIDTH-1:0] RC_TIMEOUT_W = RC_WIDTH'(RC_TIMEOUT);

  state_e                 state_q;
  logic                   engine_done_q;
  logic [RC_WIDTH-1:0]    return_code_q;
  logic                   job_valid_q;
  logic [HOST_DWIDTH-1:0] job_data_q;
  logic                   kern_abort_q;
  logic [CNT_WIDTH-1:0]   job_count_q;
  logic [1:0]             err_sticky_q;

  logic handshake;
  logic wdog_expire;

  assign handshake = (state_q == ST_DISPATCH) && job_valid_q && job_ready_i;

  // Watchdog restarts at the descriptor handshake and runs only in RUN
  jm_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (handshake),
    .en_i     (state_q == ST_RUN),
    .expire_o (wdog_expire)
  );

  // Job lifecycle FSM with registered outputs and sticky protocol errors
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      engine_done_q <= 1'b0;
      return_code_q <= '0;
      job_valid_q   <= 1'b0;
      job_data_q    <= '0;
      kern_abort_q  <= 1'b0;
      job_count_q   <= '0;
      err_sticky_q  <= 2'b00;
    end else begin
      engine_done_q <= 1'b0;
      kern_abort_q  <= 1'b0;

      if (engine_start_i && (state_q != ST_IDLE)) begin
        err_sticky_q[0] <= 1'b1;
      end
      if (kern_done_i && (state_q != ST_RUN)) begin
        err_sticky_q[1] <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (engine_start_i) begin
            job_data_q  <= jd_payload_i;
            job_valid_q <= 1'b1;
            state_q     <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          if (handshake) begin
            job_valid_q <= 1'b0;
            state_q     <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Kernel completion takes priority over a coincident timeout
          if (kern_done_i) begin
            return_code_q <= kern_rc_i;
            engine_done_q <= 1'b1;
            job_count_q   <= job_count_q + CNT_WIDTH'(1);
            state_q       <= ST_REPORT;
          end else if (wdog_expire) begin
            return_code_q <= RC_TIMEOUT_W;
            kern_abort_q  <= 1'b1;
            engine_done_q <= 1'b1;
            job_count_q   <= job_count_q + CNT_WIDTH'(1);
            state_q       <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign engine_done_o = engine_done_q;
  assign return_code_o = return_code_q;
  assign job_valid_o   = job_valid_q;
  assign job_data_o    = job_data_q;
  assign kern_abort_o  = kern_abort_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign job_count_o   = job_count_q;
  assign err_sticky_o  = err_sticky_q;

endmodule : jm_engine_if
`default_nettype wire

// File: tb/tb_jm_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_jm_engine_if
// Brief    : Self-checking bench for jm_engine_if with a return-code
//            scoreboard and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jm_engine_if;

  localparam int HD  = 64;
  localparam int RCW = 32;
  localparam int TO  = 16;
  localparam int CW  = 32;
  localparam logic [RCW-1:0] EXP_RC_TIMEOUT = 32'hDEAD_0001;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            engine_start = 1'b0;
  logic [HD-1:0]   jd_payload = '0;
  logic            engine_done;
  logic [RCW-1:0]  return_code;
  logic            job_valid;
  logic            job_ready = 1'b0;
  logic [HD-1:0]   job_data;
  logic            kern_done = 1'b0;
  logic [RCW-1:0]  kern_rc = '0;
  logic            kern_abort;
  logic            busy;
  logic [CW-1:0]   job_count;
  logic [1:0]      err_sticky;

  always #5 clk = ~clk;

  jm_engine_if #(
    .HOST_DWIDTH    (HD),
    .RC_WIDTH       (RCW),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .engine_start_i (engine_start),
    .jd_payload_i   (jd_payload),
    .engine_done_o  (engine_done),
    .return_code_o  (return_code),
    .job_valid_o    (job_valid),
    .job_ready_i    (job_ready),
    .job_data_o     (job_data),
    .kern_done_i    (kern_done),
    .kern_rc_i      (kern_rc),
    .kern_abort_o   (kern_abort),
    .busy_o         (busy),
    .job_count_o    (job_count),
    .err_sticky_o   (err_sticky)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [HD-1:0] got, input logic [HD-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected return codes in job order, plus a done counter model
  logic [RCW-1:0] exp_q[$];
  int             cnt_model = 0;
  bit             cnt_pend  = 1'b0;

  always @(negedge clk) begin
    if (cnt_pend) begin
      chk("job_count", job_count, cnt_model);
      cnt_pend = 1'b0;
    end
    if (engine_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        chk("return_code", return_code, exp_q.pop_front());
      end
      cnt_model++;
      cnt_pend = 1'b1;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Drive a one-cycle start; returns in the cycle after the start
  task automatic start_job(input logic [HD-1:0] p, input logic [RCW-1:0] rc);
    engine_start = 1'b1;
    jd_payload   = p;
    exp_q.push_back(rc);
    nxt();
    engine_start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done"},  engine_done, 0);
    chk({tag, "_valid"}, job_valid, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_cnt"},   job_count, 0);
    chk({tag, "_err"},   err_sticky, 0);
    chk({tag, "_rc"},    return_code, 0);
    chk({tag, "_abort"}, kern_abort, 0);
    chk({tag, "_data"},  job_data, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [HD-1:0] p2;
    int            k;
    bit            found;
    bit            abort_seen;

    // Reset state
    repeat (3) nxt();
    smp();
    chk_all_zero("reset");
    rst_n = 1'b1;
    nxt();

    // 1 Basic job
    job_ready = 1'b1;
    start_job({8{8'hA5}}, 32'h12);
    smp();
    chk("t1_valid_t1", job_valid, 1);
    chk("t1_data", job_data, {8{8'hA5}});
    chk("t1_busy", busy, 1);
    nxt();
    smp();
    chk("t1_valid_t2", job_valid, 0);
    repeat (8) nxt();
    kern_done = 1'b1;
    kern_rc   = 32'h12;
    nxt();
    kern_done = 1'b0;
    smp();
    chk("t1_done_t11", engine_done, 1);
    nxt();
    smp();
    chk("t1_done_1cyc", engine_done, 0);
    chk("t1_idle", busy, 0);

    // 2 Backpressure: ready low for 7 DISPATCH cycles
    job_ready = 1'b0;
    nxt();
    p2 = 64'h0123_4567_89AB_CDEF;
    start_job(p2, 32'h34);
    for (int i = 1; i <= 8; i++) begin
      job_ready = (i == 8);
      smp();
      chk("t2_valid_held", job_valid, 1);
      chk("t2_data_stable", job_data, p2);
      nxt();
    end
    job_ready = 1'b0;
    smp();
    chk("t2_valid_drop", job_valid, 0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      smp();
      chk("t2_no_early_done", engine_done, 0);
    end
    nxt();
    kern_done = 1'b1;
    kern_rc   = 32'h34;
    nxt();
    kern_done = 1'b0;
    smp();
    chk("t2_done", engine_done, 1);

    // 3 Watchdog timeout with a silent kernel
    job_ready = 1'b1;
    nxt();
    nxt();
    start_job(64'h3333_0000_0000_0003, EXP_RC_TIMEOUT);
    found = 1'b0;
    k     = 0;
    for (int c = 1; c <= 40 && !found; c++) begin
      nxt();
      smp();
      if (engine_done && !kern_abort) chk("t3_done_without_abort", 1, 0);
      if (kern_abort) begin
        found = 1'b1;
        k     = c;
        chk("t3_done_with_abort", engine_done, 1);
      end
    end
    chk("t3_abort_seen", found, 1);
    chk("t3_abort_offset", k, 17);
    nxt();
    smp();
    chk("t3_abort_1cyc", kern_abort, 0);

    // 4 kern_done coincident with the timeout cycle
    nxt();
    start_job(64'h4444_0000_0000_0004, 32'h56);
    abort_seen = 1'b0;
    kern_rc    = 32'h56;
    for (int c = 1; c <= 18; c++) begin
      nxt();
      kern_done = (c == 16);
      smp();
      if (kern_abort) abort_seen = 1'b1;
      if (c == 17) chk("t4_done", engine_done, 1);
    end
    kern_done = 1'b0;
    chk("t4_no_abort", abort_seen, 0);

    // 5 engine_start during RUN is ignored and flagged
    nxt();
    start_job(64'h5555_5555_0000_0005, 32'h78);
    nxt();
    engine_start = 1'b1;
    jd_payload   = 64'hBAD0_BAD0_BAD0_BAD0;
    nxt();
    engine_start = 1'b0;
    smp();
    chk("t5_data_kept", job_data, 64'h5555_5555_0000_0005);
    chk("t5_err", err_sticky, 2'b01);
    chk("t5_busy", busy, 1);
    nxt();
    kern_done = 1'b1;
    kern_rc   = 32'h78;
    nxt();
    kern_done = 1'b0;
    smp();
    chk("t5_done", engine_done, 1);

    // kern_done while idle only sets the sticky flag
    nxt();
    nxt();
    kern_done = 1'b1;
    kern_rc   = 32'h99;
    nxt();
    kern_done = 1'b0;
    smp();
    chk("idle_kdone_err", err_sticky, 2'b11);
    chk("idle_kdone_nodone", engine_done, 0);
    chk("idle_kdone_busy", busy, 0);

    // 6 Reset during RUN drops the job, then a fresh job runs
    nxt();
    start_job(64'h6666_0000_0000_0006, 32'h0);
    repeat (3) nxt();
    rst_n = 1'b0;
    exp_q.delete();
    cnt_model = 0;
    smp();
    chk_all_zero("t6_rst");
    nxt();
    nxt();
    rst_n = 1'b1;
    nxt();
    start_job(64'h7777_0000_0000_0007, 32'h9A);
    smp();
    chk("t6_valid", job_valid, 1);
    repeat (4) nxt();
    kern_done = 1'b1;
    kern_rc   = 32'h9A;
    nxt();
    kern_done = 1'b0;
    smp();
    chk("t6_done", engine_done, 1);
    nxt();
    nxt();
    smp();
    chk("t6_job_count", job_count, 1);
    chk("t6_err_cleared", err_sticky, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_jm_engine_if
`default_nettype wire
